// File: rtl/bcrypt_core_rx.sv
// bcrypt_core_rx: turns the byte stream from the data-distribution stage into
// little-endian 32-bit words and routes them to the core's P, MW, S and PD
// memories. Init transfers load P/MW/S; data transfers load one PD batch.
`ifndef CTRL_INIT_START
`define CTRL_INIT_START 2'd1
`endif
`ifndef CTRL_DATA_START
`define CTRL_DATA_START 2'd2
`endif
`ifndef CTRL_END
`define CTRL_END 2'd3
`endif

module bcrypt_core_rx (
   input  logic        CLK,
   input  logic        rst,
   input  logic [7:0]  din,
   input  logic [1:0]  ctrl,
   output logic        wr_en,
   output logic [1:0]  wr_sel,
   output logic [9:0]  wr_addr,
   output logic [31:0] wr_data,
   output logic        init_done,
   output logic        data_avail,
   input  logic        data_taken,
   output logic [2:0]  error
);

   // state   | meaning
   // IDLE    | waiting for a START code
   // RX_INIT | receiving the 1054-word init block (P, MW, S)
   // RX_DATA | receiving the 31-word data batch into PD
   // ERROR   | protocol violation seen; frozen until rst
   typedef enum logic [1:0] {IDLE, RX_INIT, RX_DATA, ERROR} state_t;

   localparam logic [10:0] INIT_LAST = 11'd1053;
   localparam logic [10:0] DATA_LAST = 11'd30;
   localparam logic [1:0]  SEL_P  = 2'd0;
   localparam logic [1:0]  SEL_MW = 2'd1;
   localparam logic [1:0]  SEL_S  = 2'd2;
   localparam logic [1:0]  SEL_PD = 2'd3;

   state_t      state_q, state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [10:0] word_cnt_q, word_cnt_d;
   logic [23:0] shift_q, shift_d;
   logic        wr_en_q, wr_en_d;
   logic [1:0]  wr_sel_q, wr_sel_d;
   logic [9:0]  wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic        init_fin_q, init_fin_d;
   logic        init_done_q, init_done_d;
   logic        data_avail_q, data_avail_d;
   logic [2:0]  error_q, error_d;

   logic [31:0] word;
   logic [10:0] last_word;
   logic        data_set;
   logic [2:0]  err_set;

   // next-state, word assembly, routing and flag logic
   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      word_cnt_d  = word_cnt_q;
      shift_d     = shift_q;
      wr_en_d     = 1'b0;
      wr_sel_d    = wr_sel_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      init_fin_d  = 1'b0;
      init_done_d = init_fin_q;
      data_set    = 1'b0;
      err_set     = 3'b000;
      word        = {din, shift_q};
      last_word   = (state_q == RX_INIT) ? INIT_LAST : DATA_LAST;

      case (state_q)
         IDLE: begin
            if (ctrl == `CTRL_INIT_START) begin
               state_d    = RX_INIT;
               byte_cnt_d = 2'd0;
               word_cnt_d = 11'd0;
            end else if (ctrl == `CTRL_DATA_START) begin
               // PD still holds an unconsumed batch
               if (data_avail_q) begin
                  err_set[2] = 1'b1;
               end else begin
                  state_d    = RX_DATA;
                  byte_cnt_d = 2'd0;
                  word_cnt_d = 11'd0;
               end
            end else if (ctrl != 2'd0) begin
               err_set[1] = 1'b1;
            end
         end
         RX_INIT, RX_DATA: begin
            if (ctrl == `CTRL_INIT_START || ctrl == `CTRL_DATA_START) begin
               err_set[1] = 1'b1;
            end else if (word_cnt_q > last_word) begin
               err_set[0] = 1'b1;
            end else if (ctrl == `CTRL_END &&
                         (byte_cnt_q != 2'd3 || word_cnt_q != last_word)) begin
               err_set[0] = 1'b1;
            end else begin
               shift_d    = word[31:8];
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  word_cnt_d = word_cnt_q + 11'd1;
                  wr_data_d  = word;
                  if (state_q == RX_INIT) begin
                     if (word_cnt_q < 11'd18) begin
                        wr_en_d   = 1'b1;
                        wr_sel_d  = SEL_P;
                        wr_addr_d = word_cnt_q[9:0];
                     end else if (word_cnt_q < 11'd24) begin
                        wr_en_d   = 1'b0;   // words 18-23 carry nothing the core stores
                     end else if (word_cnt_q < 11'd30) begin
                        wr_en_d   = 1'b1;
                        wr_sel_d  = SEL_MW;
                        wr_addr_d = 10'(word_cnt_q - 11'd24);
                     end else begin
                        wr_en_d   = 1'b1;
                        wr_sel_d  = SEL_S;
                        wr_addr_d = 10'(word_cnt_q - 11'd30);
                     end
                  end else begin
                     wr_en_d   = 1'b1;
                     wr_sel_d  = SEL_PD;
                     wr_addr_d = word_cnt_q[9:0];
                  end
                  if (ctrl == `CTRL_END) begin
                     state_d = IDLE;
                     if (state_q == RX_INIT) init_fin_d = 1'b1;
                     else                    data_set   = 1'b1;
                  end
               end
            end
         end
         default: ;
      endcase

      if (err_set != 3'b000) state_d = ERROR;
      error_d = error_q | err_set;

      // completion wins over a coincident data_taken
      if (data_set)        data_avail_d = 1'b1;
      else if (data_taken) data_avail_d = 1'b0;
      else                 data_avail_d = data_avail_q;
   end

   // state and output registers, synchronous reset
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q      <= IDLE;
         byte_cnt_q   <= '0;
         word_cnt_q   <= '0;
         shift_q      <= '0;
         wr_en_q      <= 1'b0;
         wr_sel_q     <= '0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         init_fin_q   <= 1'b0;
         init_done_q  <= 1'b0;
         data_avail_q <= 1'b0;
         error_q      <= '0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         word_cnt_q   <= word_cnt_d;
         shift_q      <= shift_d;
         wr_en_q      <= wr_en_d;
         wr_sel_q     <= wr_sel_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         init_fin_q   <= init_fin_d;
         init_done_q  <= init_done_d;
         data_avail_q <= data_avail_d;
         error_q      <= error_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_sel     = wr_sel_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign init_done  = init_done_q;
   assign data_avail = data_avail_q;
   assign error      = error_q;

endmodule
